mux_scan_sequencer: RTL and testbench
=====================================

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the data width of each multiplexer channel.
REQ-002 The module SHALL have parameter SETTLE, default 2, giving the number of cycles S is held before Y_in is sampled; legal range is 1..15.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is the reset: synchronous, active-high.
REQ-005 Port en  input  1  enables scanning.
REQ-006 Port ch_mask  input  4  is the per-channel scan enable; bit i enables channel i.
REQ-007 Port S  output  2  drives the select of the downstream 4-to-1 N-bit multiplexer.
REQ-008 Port Y_in  input  N  is the multiplexer output returned for sampling.
REQ-009 Port out_data  output  N  is the sampled channel value.
REQ-010 Port out_ch  output  2  is the channel index of out_data.
REQ-011 Port out_valid  output  1  marks out_data/out_ch as valid.
REQ-012 Port out_ready  input  1  is the consumer acceptance.
REQ-013 Port busy  output  1  is high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE and PRESENT.
REQ-015 In IDLE with en=1 and ch_mask!=0, the FSM SHALL load S with the first enabled channel at or after ptr (cyclic), clear the settle counter and enter SETTLE.
REQ-016 In SETTLE, S SHALL be held stable, and Y_in SHALL be captured into out_data with S into out_ch, with out_valid set and the state changed to PRESENT, on the SETTLE-th rising edge after S was loaded.
REQ-017 In SETTLE, if en=0 the FSM SHALL return to IDLE on that edge with no output produced.
REQ-018 In PRESENT, out_data, out_ch, out_valid and S SHALL hold until a clock edge with out_valid=1 and out_ready=1 (the handshake).
REQ-019 On the handshake edge, out_valid SHALL clear, and ptr and S SHALL advance to the next enabled channel strictly after the current one (cyclic, using ch_mask sampled on that edge).
REQ-020 On the handshake edge, the FSM SHALL enter SETTLE if en=1 and ch_mask!=0, else IDLE.
REQ-021 A PRESENT state already entered SHALL complete its handshake even if en falls.
REQ-022 With exactly one enabled channel, the FSM SHALL resample the same channel, keeping S constant.
REQ-023 Changes to ch_mask during SETTLE or PRESENT SHALL NOT abort the current sample.
REQ-024 Sustained throughput with out_ready=1 SHALL be one sample every SETTLE+1 cycles.
REQ-025 out_data SHALL change only on capture edges or reset.

Reset
REQ-026 When rst=1 on a clock edge, the block SHALL set state=IDLE, ptr=0, S=2'b00, out_data=0, out_ch=0, out_valid=0, busy=0 and settle counter=0, overriding all other activity including mid-handshake.

Configuration
REQ-027 When macro MUX_SCAN_CHANGE_ONLY_EN is defined, the block SHALL keep four N-bit shadow registers, reset to 0 and updated on each handshake.
REQ-028 With MUX_SCAN_CHANGE_ONLY_EN defined, a capture equal to the shadow register of its channel SHALL NOT assert out_valid; S SHALL advance as on a handshake, and the FSM SHALL go directly to SETTLE or IDLE.
REQ-029 Without MUX_SCAN_CHANGE_ONLY_EN, every capture SHALL be presented, and no shadow registers SHALL exist.

Verification (bench models the 4-to-1 mux with A=0011, B=0110, C=1100, D=1001, N=4, SETTLE=2)
REQ-030 Reset test: assert rst for 2 cycles -> S=00, out_valid=0, out_data=0000, busy=0.
REQ-031 Full scan test: en=1, ch_mask=1111, out_ready=1 -> the bench SHALL see (out_ch,out_data) = (0,0011),(1,0110),(2,1100),(3,1001),(0,0011), with out_valid pulses 3 cycles apart.
REQ-032 Sparse mask test: ch_mask=0101 -> outputs SHALL alternate (0,0011),(2,1100); S SHALL never equal 01 or 11.
REQ-033 Backpressure test: out_ready=0 for 5 cycles while out_valid=1 -> out_data, out_ch and S SHALL be held; on out_ready=1, exactly one handshake SHALL occur.
REQ-034 Abort test: drop en during SETTLE -> IDLE within 1 cycle with no out_valid; assert rst during PRESENT -> REQ-026 values on the next edge.
REQ-035 Change-only test (MUX_SCAN_CHANGE_ONLY_EN defined), constant inputs: the bench SHALL see exactly 4 outputs and then none.
REQ-036 Change-only test (MUX_SCAN_CHANGE_ONLY_EN defined), set C=1111: only (2,1111) SHALL be emitted next.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scans the enabled channels of an external 4:1 mux and presents each settled sample.
// Latency: the sample is captured SETTLE cycles after S is driven; out_valid rises on the capture edge.
// Backpressure: a presented sample, and S with it, holds until out_valid&out_ready; change-only mode via MUX_SCAN_CHANGE_ONLY_EN.
module mux_scan_sequencer #(
   parameter int N      = 4,
   parameter int SETTLE = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [3:0]   ch_mask,
   output logic [1:0]   S,
   input  logic [N-1:0] Y_in,
   output logic [N-1:0] out_data,
   output logic [1:0]   out_ch,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_PRESENT} state_t;

   state_t       state, state_nxt;
   logic [1:0]   ptr, ptr_nxt;
   logic [1:0]   s_nxt;
   logic [3:0]   cnt, cnt_nxt;
   logic [N-1:0] data_nxt;
   logic [1:0]   ch_nxt;
   logic         valid_nxt;
   logic         go;
   logic [1:0]   adv;

   // incl=1 searches from start inclusive; incl=0 searches strictly after start,
   // wrapping back onto start last so a single enabled channel reselects itself.
   function automatic logic [1:0] pick_ch(input logic [3:0] m, input logic [1:0] start,
                                          input logic incl);
      logic [1:0] base;
      logic [1:0] c;
      logic [1:0] r;
      logic       found;
      base  = incl ? start : start + 2'd1;
      r     = start;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         c = base + 2'(i);
         if (!found && m[c]) begin
            r     = c;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   assign go   = en && (ch_mask != 4'b0000);
   assign adv  = pick_ch(ch_mask, S, 1'b0);
   assign busy = (state != ST_IDLE);

`ifdef MUX_SCAN_CHANGE_ONLY_EN
   logic [N-1:0] shadow [4];
   logic         shadow_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) shadow[i] <= '0;
      end else if (shadow_we) begin
         shadow[out_ch] <= out_data;
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      s_nxt     = S;
      cnt_nxt   = cnt;
      data_nxt  = out_data;
      ch_nxt    = out_ch;
      valid_nxt = out_valid;
`ifdef MUX_SCAN_CHANGE_ONLY_EN
      shadow_we = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (go) begin
               s_nxt     = pick_ch(ch_mask, ptr, 1'b1);
               cnt_nxt   = 4'd0;
               state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!en) begin
               cnt_nxt   = 4'd0;
               state_nxt = ST_IDLE;
            end else if (cnt == 4'(SETTLE - 1)) begin
`ifdef MUX_SCAN_CHANGE_ONLY_EN
               if (Y_in == shadow[S]) begin
                  // Unchanged sample: skip presentation and move straight on.
                  s_nxt     = adv;
                  ptr_nxt   = adv;
                  cnt_nxt   = 4'd0;
                  state_nxt = go ? ST_SETTLE : ST_IDLE;
               end else begin
                  data_nxt  = Y_in;
                  ch_nxt    = S;
                  valid_nxt = 1'b1;
                  state_nxt = ST_PRESENT;
               end
`else
               data_nxt  = Y_in;
               ch_nxt    = S;
               valid_nxt = 1'b1;
               state_nxt = ST_PRESENT;
`endif
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         ST_PRESENT: begin
            // en is deliberately ignored until the handshake completes.
            if (out_valid && out_ready) begin
               valid_nxt = 1'b0;
               s_nxt     = adv;
               ptr_nxt   = adv;
               cnt_nxt   = 4'd0;
               state_nxt = go ? ST_SETTLE : ST_IDLE;
`ifdef MUX_SCAN_CHANGE_ONLY_EN
               shadow_we = 1'b1;
`endif
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= 2'd0;
         S         <= 2'd0;
         cnt       <= 4'd0;
         out_data  <= '0;
         out_ch    <= 2'd0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         S         <= s_nxt;
         cnt       <= cnt_nxt;
         out_data  <= data_nxt;
         out_ch    <= ch_nxt;
         out_valid <= valid_nxt;
      end
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer with a modelled 4:1 mux (A=0011 B=0110 C=1100 D=1001).
module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] ch_mask = 4'b0000;
   logic [1:0] s;
   logic [3:0] y_in;
   logic [3:0] out_data;
   logic [1:0] out_ch;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       busy;

   logic [3:0] ch_val [4];
   assign y_in = ch_val[s];

   mux_scan_sequencer #(.N(4), .SETTLE(2)) dut (
      .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .S(s), .Y_in(y_in),
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] ch;
      logic [3:0] dat;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   hs_count = 0;
   int   last_cyc = 0;
   bit   have_last = 0;
   bit   spacing_on = 0;
   bit   check_s = 0;
   logic [3:0] allowed_s = 4'b1111;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: every handshake pops and checks the next expected sample.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         hs_count++;
         if (q.size() == 0) begin
            check("unexpected_output", {26'd0, out_ch, out_data}, 32'hFFFF_FFFF);
         end else begin
            e = q.pop_front();
            check("out_ch", {30'd0, out_ch}, {30'd0, e.ch});
            check("out_data", {28'd0, out_data}, {28'd0, e.dat});
            if (spacing_on && have_last)
               check("valid_spacing", cyc - last_cyc, 3);
            have_last = 1;
            last_cyc  = cyc;
         end
      end
      if (check_s && busy && !rst)
         check("s_allowed", {31'd0, allowed_s[s]}, 1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (q.size() != 0 && k < budget) begin
         tick(1);
         k++;
      end
      check("drain_timeout", q.size(), 0);
      q.delete();
   endtask

   task automatic wait_valid(input int budget);
      int k = 0;
      while (!out_valid && k < budget) begin
         tick(1);
         k++;
      end
      check("valid_timeout", {31'd0, out_valid}, 1);
   endtask

   task automatic push(input logic [1:0] ch, input logic [3:0] dat);
      exp_t e;
      e.ch  = ch;
      e.dat = dat;
      q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int hs_base;
      ch_val[0] = 4'b0011;
      ch_val[1] = 4'b0110;
      ch_val[2] = 4'b1100;
      ch_val[3] = 4'b1001;

      // Reset
      rst = 1'b1;
      tick(2);
      check("rst_s", {30'd0, s}, 0);
      check("rst_valid", {31'd0, out_valid}, 0);
      check("rst_data", {28'd0, out_data}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      rst = 1'b0;
      tick(1);

`ifndef MUX_SCAN_CHANGE_ONLY_EN
      spacing_on = 1;

      // Full scan
      push(2'd0, 4'b0011); push(2'd1, 4'b0110); push(2'd2, 4'b1100);
      push(2'd3, 4'b1001); push(2'd0, 4'b0011);
      have_last = 0;
      ch_mask = 4'b1111; out_ready = 1'b1; en = 1'b1;
      wait_drain(60);
      en = 1'b0;
      tick(3);
      check("scan_idle_busy", {31'd0, busy}, 0);

      // Sparse mask: ptr now 1, so the scan resumes at channel 2
      push(2'd2, 4'b1100); push(2'd0, 4'b0011); push(2'd2, 4'b1100); push(2'd0, 4'b0011);
      have_last = 0;
      allowed_s = 4'b0101; check_s = 1;
      ch_mask = 4'b0101; en = 1'b1;
      wait_drain(60);
      en = 1'b0;
      tick(3);
      check_s = 0;

      // Backpressure: scan resumes at channel 2
      push(2'd2, 4'b1100);
      have_last = 0;
      out_ready = 1'b0; ch_mask = 4'b1111; en = 1'b1;
      wait_valid(20);
      hs_base = hs_count;
      for (int i = 0; i < 5; i++) begin
         check("bp_data", {28'd0, out_data}, 32'hC);
         check("bp_ch", {30'd0, out_ch}, 2);
         check("bp_s", {30'd0, s}, 2);
         check("bp_valid", {31'd0, out_valid}, 1);
         tick(1);
      end
      en = 1'b0; out_ready = 1'b1;
      tick(3);
      check("bp_one_handshake", hs_count, hs_base + 1);
      check("bp_valid_clear", {31'd0, out_valid}, 0);
      check("bp_idle", {31'd0, busy}, 0);
      wait_drain(5);

      // Abort in SETTLE: ptr now 3
      en = 1'b1;
      tick(1);
      check("abort_busy", {31'd0, busy}, 1);
      check("abort_s", {30'd0, s}, 3);
      en = 1'b0;
      tick(1);
      check("abort_idle", {31'd0, busy}, 0);
      tick(3);
      check("abort_novalid", {31'd0, out_valid}, 0);

      // Reset while presenting (and mid-handshake)
      out_ready = 1'b0; en = 1'b1;
      wait_valid(20);
      check("pres_data", {28'd0, out_data}, 32'h9);
      check("pres_ch", {30'd0, out_ch}, 3);
      rst = 1'b1; en = 1'b0; out_ready = 1'b1;
      tick(1);
      check("mid_rst_s", {30'd0, s}, 0);
      check("mid_rst_valid", {31'd0, out_valid}, 0);
      check("mid_rst_data", {28'd0, out_data}, 0);
      check("mid_rst_ch", {30'd0, out_ch}, 0);
      check("mid_rst_busy", {31'd0, busy}, 0);
      rst = 1'b0;
      tick(1);
      push(2'd0, 4'b0011);
      have_last = 0;
      en = 1'b1;
      wait_drain(20);
      en = 1'b0;
      tick(3);

      // Single enabled channel: ptr now 1
      push(2'd1, 4'b0110); push(2'd1, 4'b0110); push(2'd1, 4'b0110);
      have_last = 0;
      allowed_s = 4'b0010; check_s = 1;
      ch_mask = 4'b0010; en = 1'b1;
      wait_drain(40);
      en = 1'b0;
      tick(3);
      check_s = 0;
`else
      // Change-only: one pass of outputs, then silence on constant inputs
      hs_base = hs_count;
      push(2'd0, 4'b0011); push(2'd1, 4'b0110); push(2'd2, 4'b1100); push(2'd3, 4'b1001);
      ch_mask = 4'b1111; out_ready = 1'b1; en = 1'b1;
      wait_drain(60);
      tick(40);
      check("co_four_outputs", hs_count, hs_base + 4);
      push(2'd2, 4'b1111);
      ch_val[2] = 4'b1111;
      wait_drain(30);
      en = 1'b0;
      tick(5);
      check("co_one_more", hs_count, hs_base + 5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
